// File: rtl/vga_menu_overlay_ctrl.sv
// On-screen menu overlay: navigation FSM (show/hide, page, cursor, selection) plus registered
// per-pixel overlay conditions for the VGA colour mux. Optional auto-hide: define MENU_AUTOHIDE_EN.
module vga_menu_overlay_ctrl #(
  parameter int          N_PAGES        = 4,
  parameter logic [31:0] ITEM_CNTS      = 32'h3453,
  parameter int          PANEL_X0       = 0,
  parameter int          PANEL_Y0       = 832,
  parameter int          PANEL_W        = 241,
  parameter int          PANEL_H        = 192,
  parameter int          BORDER         = 3,
  parameter int          ROW_Y0         = 864,
  parameter int          ROW_H          = 16,
  parameter int          TIMEOUT_FRAMES = 600
) (
  input  logic        CLK_VGA,
  input  logic        RST_N,
  input  logic        menu_toggle,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  input  logic        frame_tick,
  input  logic [11:0] VGA_HORZ_COORD,
  input  logic [11:0] VGA_VERT_COORD,
  input  logic [14:0] item_text_hit,
  input  logic        header_text_hit,
  output logic        menu_visible,
  output logic [2:0]  menu_page,
  output logic [3:0]  cursor_idx,
  output logic        sel_valid,
  output logic [2:0]  sel_page,
  output logic [3:0]  sel_item,
  output logic        Condition_For_Panel,
  output logic        Condition_For_Border,
  output logic        Condition_For_Text,
  output logic        Condition_For_Cursor_Row,
  output logic        Condition_For_Cursor_Text
);

  typedef enum logic {HIDDEN, SHOWN} state_t;

  state_t     state_reg;
  logic [2:0] page_reg;
  logic [3:0] cursor_reg;
  logic       menu_visible_reg;
  logic       sel_valid_reg;
  logic [2:0] sel_page_reg;
  logic [3:0] sel_item_reg;
  logic [3:0] cnt_cur;
  logic       any_btn;
  logic       hide_evt;

  assign cnt_cur = ITEM_CNTS[{page_reg, 2'b00} +: 4];
  assign any_btn = menu_toggle | btn_up | btn_down | btn_sel;

`ifdef MENU_AUTOHIDE_EN
  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  logic [TW-1:0] frame_cnt_reg;
  logic          timeout_hit;

  // A button in the timeout cycle wins: it both suppresses the hide and clears the count.
  assign timeout_hit = frame_tick & ~any_btn & (frame_cnt_reg == TW'(TIMEOUT_FRAMES - 1));
  assign hide_evt    = menu_toggle | timeout_hit;

  always_ff @(posedge CLK_VGA) begin
    if (!RST_N || state_reg != SHOWN || any_btn || timeout_hit)
      frame_cnt_reg <= '0;
    else if (frame_tick)
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
  end
`else
  assign hide_evt = menu_toggle;
`endif

  always_ff @(posedge CLK_VGA) begin
    if (!RST_N) begin
      state_reg        <= HIDDEN;
      page_reg         <= '0;
      cursor_reg       <= '0;
      menu_visible_reg <= 1'b0;
      sel_valid_reg    <= 1'b0;
      sel_page_reg     <= '0;
      sel_item_reg     <= '0;
    end else begin
      sel_valid_reg <= 1'b0;
      case (state_reg)
        HIDDEN: begin
          if (menu_toggle) begin
            state_reg        <= SHOWN;
            menu_visible_reg <= 1'b1;
            page_reg         <= '0;
            cursor_reg       <= '0;
          end
        end
        SHOWN: begin
          if (hide_evt) begin
            state_reg        <= HIDDEN;
            menu_visible_reg <= 1'b0;
            page_reg         <= '0;
            cursor_reg       <= '0;
          end else if (btn_sel) begin
            if (page_reg == 3'd0) begin
              // Main-page rows open sub-pages; rows past the last page are plain items.
              if ({1'b0, cursor_reg} + 5'd1 < 5'(N_PAGES)) begin
                page_reg   <= 3'(cursor_reg + 4'd1);
                cursor_reg <= '0;
              end else begin
                sel_valid_reg <= 1'b1;
                sel_page_reg  <= 3'd0;
                sel_item_reg  <= cursor_reg;
              end
            end else if (cursor_reg == cnt_cur - 4'd1) begin
              page_reg   <= '0;
              cursor_reg <= {1'b0, page_reg} - 4'd1;
            end else begin
              sel_valid_reg <= 1'b1;
              sel_page_reg  <= page_reg;
              sel_item_reg  <= cursor_reg;
            end
          end else if (btn_down && !btn_up) begin
            cursor_reg <= (cursor_reg == cnt_cur - 4'd1) ? 4'd0 : cursor_reg + 4'd1;
          end else if (btn_up && !btn_down) begin
            cursor_reg <= (cursor_reg == 4'd0) ? cnt_cur - 4'd1 : cursor_reg - 4'd1;
          end
        end
        default: state_reg <= HIDDEN;
      endcase
    end
  end

  // Offsets relative to the panel origin; an x or y left of/above the panel wraps to a huge value.
  logic [31:0] dx, dy, ry;
  logic        in_panel, on_border, inner;
  logic [15:0] row_hit, item_hit_w, cursor_oh;

  assign dx        = {20'd0, VGA_HORZ_COORD} - 32'(PANEL_X0);
  assign dy        = {20'd0, VGA_VERT_COORD} - 32'(PANEL_Y0);
  assign ry        = {20'd0, VGA_VERT_COORD} - 32'(ROW_Y0);
  assign in_panel  = (dx < 32'(PANEL_W)) & (dy < 32'(PANEL_H));
  assign on_border = in_panel & ((dx < 32'(BORDER)) | (dx > 32'(PANEL_W - 1 - BORDER)) |
                                 (dy < 32'(BORDER)) | (dy > 32'(PANEL_H - 1 - BORDER)));
  assign inner     = in_panel & ~on_border;

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_row
      assign row_hit[gi] = inner & ((ry - 32'(gi * ROW_H)) < 32'(ROW_H)) & (4'(gi) < cnt_cur);
    end
  endgenerate
  assign row_hit[15] = 1'b0;

  assign item_hit_w = {1'b0, item_text_hit};
  assign cursor_oh  = 16'd1 << cursor_reg;

  logic panel_reg, border_reg, text_reg, cursor_row_reg, cursor_text_reg;

  always_ff @(posedge CLK_VGA) begin
    if (!RST_N || state_reg != SHOWN) begin
      panel_reg       <= 1'b0;
      border_reg      <= 1'b0;
      text_reg        <= 1'b0;
      cursor_row_reg  <= 1'b0;
      cursor_text_reg <= 1'b0;
    end else begin
      panel_reg       <= in_panel;
      border_reg      <= on_border;
      text_reg        <= (header_text_hit & in_panel) | (|(row_hit & item_hit_w & ~cursor_oh));
      cursor_row_reg  <= row_hit[cursor_reg];
      cursor_text_reg <= row_hit[cursor_reg] & item_hit_w[cursor_reg];
    end
  end

  assign menu_visible              = menu_visible_reg;
  assign menu_page                 = page_reg;
  assign cursor_idx                = cursor_reg;
  assign sel_valid                 = sel_valid_reg;
  assign sel_page                  = sel_page_reg;
  assign sel_item                  = sel_item_reg;
  assign Condition_For_Panel       = panel_reg;
  assign Condition_For_Border      = border_reg;
  assign Condition_For_Text        = text_reg;
  assign Condition_For_Cursor_Row  = cursor_row_reg;
  assign Condition_For_Cursor_Text = cursor_text_reg;

endmodule

// File: tb/tb_vga_menu_overlay_ctrl.sv
// Scoreboard bench for vga_menu_overlay_ctrl: stimulus pushes model-predicted outputs into a queue,
// a monitor pops and compares one entry per clock.
module tb_vga_menu_overlay_ctrl;

  localparam int          N_PAGES   = 4;
  localparam logic [31:0] ITEM_CNTS = 32'h3453;
  localparam int          PX0 = 0, PY0 = 832, PW = 241, PH = 192, BD = 3;
  localparam int          RY0 = 864, RH = 16, TO = 4;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;
  logic        menu_toggle = 0, btn_up = 0, btn_down = 0, btn_sel = 0, frame_tick = 0;
  logic [11:0] VGA_HORZ_COORD = '0, VGA_VERT_COORD = '0;
  logic [14:0] item_text_hit = '0;
  logic        header_text_hit = 0;
  logic        menu_visible, sel_valid;
  logic [2:0]  menu_page, sel_page;
  logic [3:0]  cursor_idx, sel_item;
  logic        c_panel, c_border, c_text, c_crow, c_ctext;

  vga_menu_overlay_ctrl #(
    .N_PAGES(N_PAGES), .ITEM_CNTS(ITEM_CNTS), .PANEL_X0(PX0), .PANEL_Y0(PY0),
    .PANEL_W(PW), .PANEL_H(PH), .BORDER(BD), .ROW_Y0(RY0), .ROW_H(RH), .TIMEOUT_FRAMES(TO)
  ) dut (
    .CLK_VGA(clk), .RST_N(RST_N), .menu_toggle(menu_toggle), .btn_up(btn_up),
    .btn_down(btn_down), .btn_sel(btn_sel), .frame_tick(frame_tick),
    .VGA_HORZ_COORD(VGA_HORZ_COORD), .VGA_VERT_COORD(VGA_VERT_COORD),
    .item_text_hit(item_text_hit), .header_text_hit(header_text_hit),
    .menu_visible(menu_visible), .menu_page(menu_page), .cursor_idx(cursor_idx),
    .sel_valid(sel_valid), .sel_page(sel_page), .sel_item(sel_item),
    .Condition_For_Panel(c_panel), .Condition_For_Border(c_border),
    .Condition_For_Text(c_text), .Condition_For_Cursor_Row(c_crow),
    .Condition_For_Cursor_Text(c_ctext)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vis; int page; int cur;
    bit sv; int sp; int si;
    bit pan; bit bor; bit txt; bit crow; bit ctxt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;

  // Reference model state
  bit m_vis = 0;
  int m_page = 0, m_cur = 0, m_cnt = 0;

  function automatic int cnt_of(int p);
    return int'((ITEM_CNTS >> (4 * p)) & 32'hF);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic hide_menu();
    m_vis = 0; m_page = 0; m_cur = 0; m_cnt = 0;
  endtask

  task automatic step(input bit rn, input bit tg, input bit up, input bit dn, input bit sl,
                      input bit ft, input logic [11:0] x, input logic [11:0] y,
                      input logic [14:0] ih, input bit hh);
    exp_t e;
    int   xi, yi, c, row;
    bit   to_hide;
    @(negedge clk);
    RST_N = rn; menu_toggle = tg; btn_up = up; btn_down = dn; btn_sel = sl; frame_tick = ft;
    VGA_HORZ_COORD = x; VGA_VERT_COORD = y; item_text_hit = ih; header_text_hit = hh;
    e = '{default: 0};
    if (!rn) begin
      hide_menu();
    end else begin
      // Pixel conditions from the state before this edge.
      if (m_vis) begin
        xi = int'(x); yi = int'(y);
        e.pan = (xi >= PX0) && (xi < PX0 + PW) && (yi >= PY0) && (yi < PY0 + PH);
        e.bor = e.pan && ((xi - PX0 < BD) || (PX0 + PW - 1 - xi < BD) ||
                          (yi - PY0 < BD) || (PY0 + PH - 1 - yi < BD));
        row = -1;
        if (e.pan && !e.bor && yi >= RY0) begin
          row = (yi - RY0) / RH;
          if (row >= cnt_of(m_page)) row = -1;
        end
        e.crow = (row == m_cur);
        e.ctxt = e.crow && ih[m_cur];
        e.txt  = (hh && e.pan) || (row >= 0 && row != m_cur && ih[row]);
      end
      c = cnt_of(m_page);
      if (!m_vis) begin
        if (tg) begin m_vis = 1; m_page = 0; m_cur = 0; m_cnt = 0; end
      end else if (tg) begin
        hide_menu();
      end else begin
        to_hide = 0;
`ifdef MENU_AUTOHIDE_EN
        if (up || dn || sl) m_cnt = 0;
        else if (ft) begin
          m_cnt++;
          if (m_cnt == TO) to_hide = 1;
        end
`endif
        if (to_hide) hide_menu();
        else if (sl) begin
          if (m_page == 0) begin
            if (m_cur + 1 < N_PAGES) begin m_page = m_cur + 1; m_cur = 0; end
            else begin e.sv = 1; e.sp = 0; e.si = m_cur; end
          end else if (m_cur == c - 1) begin
            m_cur = m_page - 1; m_page = 0;
          end else begin
            e.sv = 1; e.sp = m_page; e.si = m_cur;
          end
        end else if (up && !dn) m_cur = (m_cur + c - 1) % c;
        else if (dn && !up) m_cur = (m_cur + 1) % c;
      end
    end
    e.vis = m_vis; e.page = m_page; e.cur = m_cur;
    sb.push_back(e);
  endtask

  task automatic nav(input bit tg, input bit up, input bit dn, input bit sl);
    step(1, tg, up, dn, sl, 0, 12'($urandom_range(0, 299)), 12'($urandom_range(820, 1040)),
         15'($urandom), 1'($urandom));
  endtask

  task automatic pix(input int x, input int y, input logic [14:0] ih, input bit hh);
    step(1, 0, 0, 0, 0, 0, 12'(x), 12'(y), ih, hh);
  endtask

  // Monitor: one scoreboard entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("menu_visible", int'(menu_visible), int'(e.vis));
        chk("menu_page", int'(menu_page), e.page);
        chk("cursor_idx", int'(cursor_idx), e.cur);
        chk("sel_valid", int'(sel_valid), int'(e.sv));
        if (e.sv) begin
          chk("sel_page", int'(sel_page), e.sp);
          chk("sel_item", int'(sel_item), e.si);
          $display("[TB] selection page=%0d item=%0d", e.sp, e.si);
        end
        chk("cond_panel", int'(c_panel), int'(e.pan));
        chk("cond_border", int'(c_border), int'(e.bor));
        chk("cond_text", int'(c_text), int'(e.txt));
        chk("cond_cursor_row", int'(c_crow), int'(e.crow));
        chk("cond_cursor_text", int'(c_ctext), int'(e.ctxt));
      end
    end
  end

  initial begin
    bit rn, tg, up, dn, sl, ft;
    logic [11:0] x, y;
    // Reset with buttons active
    step(0, 1, 1, 0, 1, 1, 12'd40, 12'd870, 15'h7FFF, 1);
    step(0, 0, 0, 1, 1, 0, 12'd1, 12'd900, 15'h7FFF, 1);
    step(0, 1, 1, 1, 1, 1, 12'd40, 12'd870, 15'h7FFF, 1);
    nav(1, 0, 0, 0);                                      // show
    nav(0, 0, 1, 0); nav(0, 0, 1, 0); nav(0, 0, 1, 0);    // 1,2,0
    nav(0, 1, 0, 0);                                      // 2
    nav(0, 0, 1, 0);                                      // 0
    nav(0, 0, 0, 1);                                      // page 1
    nav(0, 0, 1, 0); nav(0, 0, 1, 0); nav(0, 0, 0, 1);    // select 1/2
    nav(0, 0, 1, 0); nav(0, 0, 1, 0); nav(0, 0, 0, 1);    // Back -> page 0, cursor 0
    pix(1, 900, 15'h0000, 0);
    pix(40, 870, 15'h0001, 0);
    pix(300, 900, 15'h7FFF, 1);
    pix(0, 832, 15'h7FFF, 1);
    pix(240, 1023, 15'h0000, 1);
    pix(3, 879, 15'h0003, 0);
    pix(40, 880, 15'h0002, 0);
    pix(40, 912, 15'h7FFF, 0);                            // row 3 absent on page 0
    nav(1, 0, 0, 1);                                      // hide, no selection
    nav(1, 0, 0, 0); nav(0, 1, 1, 0);                     // show, up+down no move
    nav(0, 0, 1, 0); nav(0, 0, 0, 1); nav(0, 0, 1, 0);    // page 2, cursor 1
    step(0, 0, 1, 0, 0, 0, 12'd40, 12'd870, 15'h7FFF, 1); // reset mid-page
    nav(0, 0, 0, 0);
`ifdef MENU_AUTOHIDE_EN
    nav(1, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 1, 12'd40, 12'd870, 15'h0, 0);
    nav(1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 1, 12'd40, 12'd870, 15'h0, 0);
    step(1, 0, 0, 1, 0, 1, 12'd40, 12'd870, 15'h0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 1, 12'd40, 12'd870, 15'h0, 0);
`endif
    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      rn = ($urandom_range(0, 499) != 0);
      tg = ($urandom_range(0, 39) == 0);
      up = ($urandom_range(0, 3) == 0);
      dn = ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 9) == 0);
      ft = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) begin
        x = 12'($urandom); y = 12'($urandom);
      end else begin
        x = 12'($urandom_range(0, 299)); y = 12'($urandom_range(800, 1060));
      end
      step(rn, tg, up, dn, sl, ft, x, y, 15'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_menu_overlay_ctrl.md
Name: vga_menu_overlay_ctrl

Overview:
Parametrised successor to the fixed four-page on-screen menu overlay. Owns menu navigation: show/hide, page, cursor, back, and selection pulses. Also produces registered per-pixel overlay conditions (panel, border, item text, cursor-row highlight) for the VGA colour mux. Glyph hits come from external text renderers chosen by `menu_page`; the block itself draws no fonts.

Parameters:
- N_PAGES, 4, number of pages; page 0 is the main page (max 8).
- ITEM_CNTS, 32'h3453, packed 4-bit selectable-item count per page, page p at bits [4p+3:4p]; each count is 1..15.
- PANEL_X0, 0, panel left x.
- PANEL_Y0, 832, panel top y.
- PANEL_W, 241, panel width in pixels.
- PANEL_H, 192, panel height in pixels.
- BORDER, 3, border thickness in pixels.
- ROW_Y0, 864, top y of item row 0.
- ROW_H, 16, item row pitch in pixels.
- TIMEOUT_FRAMES, 600, auto-hide delay in frames (optional feature only).

Ports:
- CLK_VGA  in  1  pixel clock.
- RST_N  in  1  reset.
- menu_toggle  in  1  one-cycle pulse: show or hide the menu.
- btn_up  in  1  one-cycle pulse: cursor up.
- btn_down  in  1  one-cycle pulse: cursor down.
- btn_sel  in  1  one-cycle pulse: activate the item under the cursor.
- frame_tick  in  1  one-cycle pulse, once per frame.
- VGA_HORZ_COORD  in  12  current pixel x.
- VGA_VERT_COORD  in  12  current pixel y.
- item_text_hit  in  15  bit r: glyph pixel of row r on the current page.
- header_text_hit  in  1  glyph pixel of the page header.
- menu_visible  out  1  menu is shown.
- menu_page  out  3  current page.
- cursor_idx  out  4  current cursor row.
- sel_valid  out  1  one-cycle selection strobe.
- sel_page  out  3  page of the selection; valid with sel_valid.
- sel_item  out  4  item of the selection; valid with sel_valid.
- Condition_For_Panel  out  1  pixel is inside the panel.
- Condition_For_Border  out  1  pixel is on the panel border.
- Condition_For_Text  out  1  non-cursor text or header glyph.
- Condition_For_Cursor_Row  out  1  highlight bar behind the cursor row.
- Condition_For_Cursor_Text  out  1  glyph pixel in the cursor row.

Interface decision: one clock; reset is synchronous and active-low. Clock is CLK_VGA, reset is RST_N, sampled only on the rising edge of CLK_VGA.

Behaviour:
- Reset (RST_N=0 at a clock edge): all outputs 0; state HIDDEN; page 0; cursor 0; pixel pipeline flushed. Reset mid-navigation discards everything.
- FSM states: HIDDEN, SHOWN.
  - HIDDEN, on menu_toggle: go to SHOWN, page 0, cursor 0. All buttons are ignored while HIDDEN.
  - SHOWN, on menu_toggle: go to HIDDEN. Page and cursor reset to 0.
- Event priority per cycle: menu_toggle > btn_sel > btn_up/btn_down. If btn_up and btn_down arrive together: no move.
- Let CNT = ITEM_CNTS for the current page.
- btn_down: cursor = (cursor == CNT-1) ? 0 : cursor+1 (wraps).
- btn_up: cursor = (cursor == 0) ? CNT-1 : cursor-1 (wraps).
- btn_sel on page 0, cursor k with k+1 < N_PAGES: page = k+1, cursor 0. No sel_valid.
- btn_sel on page 0, cursor k with k+1 >= N_PAGES: sel_valid with page 0, item k.
- btn_sel on page p>0, last item (CNT-1) is Back: page = 0, cursor = p-1. No sel_valid.
- btn_sel on page p>0, any other item: sel_valid=1 for exactly one cycle, the cycle after btn_sel. sel_page=p, sel_item=cursor. Menu stays on page p.
- menu_visible, menu_page and cursor_idx update on the edge that samples the event (1-cycle latency).
- Pixel pipeline: conditions are computed from coords and *_hit in cycle n and registered, so they are valid in cycle n+1. All five are 0 when not SHOWN.
- x = VGA_HORZ_COORD, y = VGA_VERT_COORD. All compares are unsigned 12-bit.
- Panel: PANEL_X0 <= x <= PANEL_X0+PANEL_W-1 and PANEL_Y0 <= y <= PANEL_Y0+PANEL_H-1.
- Border: panel, and within BORDER pixels of any panel edge.
- Row r: ROW_Y0+r*ROW_H <= y < ROW_Y0+(r+1)*ROW_H, panel, not border. Only rows r < CNT exist.
- Cursor_Row: row == cursor.
- Cursor_Text: Cursor_Row & item_text_hit[cursor].
- Text: header_text_hit, or item_text_hit[r] for any valid r != cursor. Each item bit is masked to its own row region; header is masked to panel.
- Coordinates off-screen or outside the panel: all pixel outputs 0.

Optional Feature:
- Macro: MENU_AUTOHIDE_EN.
- Defined: a frame counter, width ceil(log2(TIMEOUT_FRAMES+1)), increments on frame_tick while SHOWN. It clears on any button pulse, on entering SHOWN, and on reset. When it reaches TIMEOUT_FRAMES on a frame_tick, the FSM goes to HIDDEN as if menu_toggle had occurred. Timeout and a button in the same cycle: the button wins and the counter clears.
- Not defined: no counter is built, frame_tick is ignored, and only menu_toggle hides the menu.

Test Plan:
1. Reset with buttons toggling → all outputs 0. One menu_toggle → menu_visible=1 next cycle, page 0, cursor 0.
2. Page 0: btn_down ×3 → cursor 1,2,0. btn_up → cursor 2. btn_sel on cursor 0 → page 1, cursor 0, sel_valid never asserted.
3. Page 1 (5 items): btn_down ×2, btn_sel → sel_valid for one cycle, sel_page=1, sel_item=2. Then btn_down ×2, btn_sel (Back, item 4) → page 0, cursor 0.
4. Pixel (1,900) with panel shown → Border=1 one cycle later. Pixel (40,870), cursor 0, item_text_hit[0]=1 → Cursor_Text=1, Text=0. Pixel (300,900) → all 0.
5. Same-cycle events: menu_toggle+btn_sel → hidden, no sel_valid. btn_up+btn_down → cursor unchanged. RST_N low mid-page 2 → page 0, HIDDEN.
6. With MENU_AUTOHIDE_EN and TIMEOUT_FRAMES=4: 4 frame_ticks with no input → hidden. btn_down at tick 3 → still shown after tick 4, hides after 4 further ticks.
